// File: rtl/ama_add_if.sv
// Bundle of the request, shared-adder and response signals around the add scheduler.
// The slave modport is the scheduler; the master modport is the client/adder side.
interface ama_add_if #(
   parameter int unsigned W = 24
);
   logic [3:0]     req_valid;
   logic [3:0]     req_ready;
   logic [4*W-1:0] req_a;
   logic [4*W-1:0] req_b;
   logic [3:0]     req_cin;
   logic [W-1:0]   add_a;
   logic [W-1:0]   add_b;
   logic           add_cin;
   logic [W-1:0]   add_s;
   logic           add_cout;
   logic           rsp_valid;
   logic           rsp_ready;
   logic [1:0]     rsp_id;
   logic [W-1:0]   rsp_sum;
   logic           rsp_cout;
   logic           busy;

   modport slave (
      input  req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
      output req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );

   modport master (
      output req_valid, req_a, req_b, req_cin, add_s, add_cout, rsp_ready,
      input  req_ready, add_a, add_b, add_cin, rsp_valid, rsp_id, rsp_sum, rsp_cout, busy
   );
endinterface

// File: rtl/ama_add_scheduler.sv
// Round-robin scheduler sharing one multi-cycle approximate adder among four requesters.
// Operands are registered and held for LAT cycles, then the raw sum is captured and
// returned with the owner ID over a valid/ready response channel.
module ama_add_scheduler #(
   parameter int unsigned W   = 24,
   parameter int unsigned LAT = 2    // legal range 1..7 (fits the 3-bit hold counter)
) (
   input logic      clk,
   input logic      rst_n,
   ama_add_if.slave bus
);

   typedef enum logic [1:0] {StIdle, StHold, StResp} state_e;

   state_e         state_q, state_d;
   logic [1:0]     ptr_q, ptr_d;
   logic [2:0]     cnt_q, cnt_d;
   logic [1:0]     id_q, id_d;
   logic [W-1:0]   add_a_q, add_a_d;
   logic [W-1:0]   add_b_q, add_b_d;
   logic           add_cin_q, add_cin_d;
   logic [W-1:0]   sum_q, sum_d;
   logic           cout_q, cout_d;

   logic [W-1:0]   op_a [4];
   logic [W-1:0]   op_b [4];
   logic           gnt_found;
   logic [1:0]     gnt_idx;
   logic [3:0]     req_ready;

   for (genvar i = 0; i < 4; i++) begin : g_unpack
      assign op_a[i] = bus.req_a[i*W +: W];
      assign op_b[i] = bus.req_b[i*W +: W];
   end

   // Round-robin search starting at ptr; first valid requester wins.
   always_comb begin
      gnt_found = 1'b0;
      gnt_idx   = ptr_q;
      for (int k = 0; k < 4; k++) begin
         if (!gnt_found && bus.req_valid[ptr_q + 2'(k)]) begin
            gnt_found = 1'b1;
            gnt_idx   = ptr_q + 2'(k);
         end
      end
   end

   // Grant is combinational and only in IDLE; forced low while reset is asserted.
   always_comb begin
      req_ready = '0;
      if (rst_n && state_q == StIdle && gnt_found) begin
         req_ready[gnt_idx] = 1'b1;
      end
   end

   // Next-state logic: grant in IDLE, count down in HOLD, wait for accept in RESP.
   always_comb begin
      state_d   = state_q;
      ptr_d     = ptr_q;
      cnt_d     = cnt_q;
      id_d      = id_q;
      add_a_d   = add_a_q;
      add_b_d   = add_b_q;
      add_cin_d = add_cin_q;
      sum_d     = sum_q;
      cout_d    = cout_q;
      unique case (state_q)
         StIdle: begin
            if (gnt_found) begin
               add_a_d   = op_a[gnt_idx];
               add_b_d   = op_b[gnt_idx];
               add_cin_d = bus.req_cin[gnt_idx];
               id_d      = gnt_idx;
               ptr_d     = gnt_idx + 2'd1;
               cnt_d     = 3'(LAT - 1);
               state_d   = StHold;
            end
         end
         StHold: begin
            if (cnt_q == 3'd0) begin
               // Raw adder output, approximation error included.
               sum_d   = bus.add_s;
               cout_d  = bus.add_cout;
               state_d = StResp;
            end else begin
               cnt_d = cnt_q - 3'd1;
            end
         end
         StResp: begin
            if (bus.rsp_ready) begin
               state_d = StIdle;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= StIdle;
         ptr_q     <= 2'd0;
         cnt_q     <= 3'd0;
         id_q      <= 2'd0;
         add_a_q   <= '0;
         add_b_q   <= '0;
         add_cin_q <= 1'b0;
         sum_q     <= '0;
         cout_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         ptr_q     <= ptr_d;
         cnt_q     <= cnt_d;
         id_q      <= id_d;
         add_a_q   <= add_a_d;
         add_b_q   <= add_b_d;
         add_cin_q <= add_cin_d;
         sum_q     <= sum_d;
         cout_q    <= cout_d;
      end
   end

   assign bus.req_ready = req_ready;
   assign bus.add_a     = add_a_q;
   assign bus.add_b     = add_b_q;
   assign bus.add_cin   = add_cin_q;
   assign bus.rsp_valid = (state_q == StResp);
   assign bus.rsp_id    = id_q;
   assign bus.rsp_sum   = sum_q;
   assign bus.rsp_cout  = cout_q;
   assign bus.busy      = (state_q != StIdle);

   // Invariants: at most one grant, never outside IDLE, adder inputs quiet outside IDLE.
   a_gnt_onehot : assert property (@(posedge clk) disable iff (!rst_n)
      $onehot0(req_ready));
   a_gnt_idle : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != StIdle) |-> (req_ready == 4'b0000));
   a_ops_stable : assert property (@(posedge clk) disable iff (!rst_n)
      (state_q != StIdle) |=> ($stable(add_a_q) && $stable(add_b_q) && $stable(add_cin_q)));

endmodule

// File: tb/tb_ama_add_scheduler.sv
// Directed bench for ama_add_scheduler. Four instances (LAT = 2, 1, 4, 7) share the same
// stimulus; each gets an exact-adder stub delayed so that early sampling returns stale sums.
module tb_ama_add_scheduler;
   localparam int unsigned W = 24;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     req_valid;
   logic [4*W-1:0] req_a;
   logic [4*W-1:0] req_b;
   logic [3:0]     req_cin;
   logic           rsp_ready;

   logic [3:0][3:0]   rdy_v;
   logic [3:0]        vld_v;
   logic [3:0]        busy_v;
   logic [3:0]        cout_v;
   logic [3:0][1:0]   id_v;
   logic [3:0][W-1:0] sum_v;
   logic [3:0][W-1:0] adda_v;

   int cyc = 0;
   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   for (genvar g = 0; g < 4; g++) begin : g_dut
      localparam int unsigned L = (g == 0) ? 2 : (g == 1) ? 1 : (g == 2) ? 4 : 7;
      ama_add_if #(.W(W)) u_if ();
      logic [W:0] exact;

      assign u_if.req_valid = req_valid;
      assign u_if.req_a     = req_a;
      assign u_if.req_b     = req_b;
      assign u_if.req_cin   = req_cin;
      assign u_if.rsp_ready = rsp_ready;

      ama_add_scheduler #(.W(W), .LAT(L)) u_dut (
         .clk   (clk),
         .rst_n (rst_n),
         .bus   (u_if.slave)
      );

      assign exact = {1'b0, u_if.add_a} + {1'b0, u_if.add_b} + {{W{1'b0}}, u_if.add_cin};
      if (L == 1) begin : g_comb
         assign {u_if.add_cout, u_if.add_s} = exact;
      end else begin : g_pipe
         logic [W:0] pipe [L-1];
         always @(posedge clk) begin
            pipe[0] <= exact;
            for (int k = 1; k < L - 1; k++) pipe[k] <= pipe[k-1];
         end
         assign {u_if.add_cout, u_if.add_s} = pipe[L-2];
      end

      assign rdy_v[g]  = u_if.req_ready;
      assign vld_v[g]  = u_if.rsp_valid;
      assign busy_v[g] = u_if.busy;
      assign cout_v[g] = u_if.rsp_cout;
      assign id_v[g]   = u_if.rsp_id;
      assign sum_v[g]  = u_if.rsp_sum;
      assign adda_v[g] = u_if.add_a;
   end

   typedef struct {
      int           idx;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic         cin;
      logic [3:0]   rdy;
      logic [W-1:0] sum;
      logic         cout;
   } vec_t;

   vec_t vecs [6];
   int   exp_lat [4] = '{3, 2, 5, 8};

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   task automatic set_req(input int i, input logic [W-1:0] a, input logic [W-1:0] b,
                          input logic c);
      req_a[i*W +: W] = a;
      req_b[i*W +: W] = b;
      req_cin[i]      = c;
      req_valid[i]    = 1'b1;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      next_cycle();
      rst_n     = 1'b0;
      req_valid = '0;
      rsp_ready = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   // Waits (bounded) on negedges for rsp_valid of one instance; lat = -1 on timeout.
   task automatic wait_rsp(input int inst, input int t0, output int lat);
      lat = -1;
      for (int n = 0; n < 20; n++) begin
         @(negedge clk);
         if (vld_v[inst]) begin
            lat = cyc - t0;
            break;
         end
      end
   endtask

   task automatic run_vec(input vec_t v);
      int t0;
      int lat;
      next_cycle();
      req_valid = '0;
      set_req(v.idx, v.a, v.b, v.cin);
      @(negedge clk);
      chk("vec_grant", 32'(rdy_v[0]), 32'(v.rdy));
      t0 = cyc;
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("vec_ready_one_cycle", 32'(rdy_v[0]), 32'd0);
      wait_rsp(0, t0 + 1, lat);
      chk("vec_latency", 32'(lat + 1), 32'd3);
      chk("vec_id", 32'(id_v[0]), 32'(v.idx));
      chk("vec_sum", 32'(sum_v[0]), 32'(v.sum));
      chk("vec_cout", 32'(cout_v[0]), 32'(v.cout));
   endtask

   initial begin
      int t0;
      int lat;
      int ng;
      int nr;
      int last;
      int seen1;
      int lats [4];

      vecs[0] = '{2, 24'h123456, 24'h0FEDCB, 1'b1, 4'b0100, 24'h222222, 1'b0};
      vecs[1] = '{0, 24'hFFFFFF, 24'h000001, 1'b0, 4'b0001, 24'h000000, 1'b1};
      vecs[2] = '{1, 24'h800000, 24'h800000, 1'b1, 4'b0010, 24'h000001, 1'b1};
      vecs[3] = '{3, 24'h00000F, 24'h0000F0, 1'b1, 4'b1000, 24'h000100, 1'b0};
      vecs[4] = '{0, 24'hAAAAAA, 24'h555555, 1'b0, 4'b0001, 24'hFFFFFF, 1'b0};
      vecs[5] = '{0, 24'hAAAAAA, 24'h555555, 1'b1, 4'b0001, 24'h000000, 1'b1};

      req_valid = 4'hF;
      req_a     = '0;
      req_b     = '0;
      req_cin   = '0;
      rsp_ready = 1'b1;

      // Reset state, with requests pending to show req_ready is held low.
      @(negedge clk);
      chk("rst_req_ready", 32'(rdy_v[0]), 32'd0);
      chk("rst_rsp_valid", 32'(vld_v[0]), 32'd0);
      chk("rst_busy", 32'(busy_v[0]), 32'd0);
      chk("rst_add_a", 32'(adda_v[0]), 32'd0);
      chk("rst_rsp_sum", 32'(sum_v[0]), 32'd0);
      do_reset();

      // Single-request vectors.
      for (int i = 0; i < 6; i++) run_vec(vecs[i]);

      // Full contention: grants 0,1,2,3,0,1 spaced 4 cycles apart.
      do_reset();
      for (int i = 0; i < 4; i++) set_req(i, 24'(i * 16), 24'd1, 1'b0);
      ng   = 0;
      nr   = 0;
      last = 0;
      for (int n = 0; n < 40; n++) begin
         @(negedge clk);
         if (rdy_v[0] != 4'b0000) begin
            if (ng < 6) begin
               chk("cont_grant", 32'(rdy_v[0]), 32'(4'b0001 << (ng % 4)));
               if (ng > 0) chk("cont_interval", 32'(cyc - last), 32'd4);
            end
            last = cyc;
            ng++;
         end
         if (vld_v[0] && nr < 6) begin
            chk("cont_id", 32'(id_v[0]), 32'(nr % 4));
            chk("cont_sum", 32'(sum_v[0]), 32'((nr % 4) * 16 + 1));
            nr++;
         end
      end
      chk("cont_grant_count", 32'(ng >= 6), 32'd1);
      chk("cont_rsp_count", 32'(nr), 32'd6);

      // Backpressure: response held 10 cycles, requester 1 waits meanwhile.
      do_reset();
      rsp_ready = 1'b0;
      set_req(0, 24'hFFFFFF, 24'h000001, 1'b0);
      set_req(1, 24'h111111, 24'h222222, 1'b0);
      @(negedge clk);
      chk("bp_grant", 32'(rdy_v[0]), 32'b0001);
      t0 = cyc;
      next_cycle();
      req_valid[0] = 1'b0;
      wait_rsp(0, t0 + 1, lat);
      chk("bp_latency", 32'(lat + 1), 32'd3);
      for (int n = 0; n < 10; n++) begin
         if (n > 0) @(negedge clk);
         chk("bp_valid", 32'(vld_v[0]), 32'd1);
         chk("bp_sum", 32'(sum_v[0]), 32'h000000);
         chk("bp_cout", 32'(cout_v[0]), 32'd1);
         chk("bp_no_grant", 32'(rdy_v[0]), 32'd0);
      end
      next_cycle();
      rsp_ready = 1'b1;
      @(negedge clk);
      chk("bp_accept_cycle_valid", 32'(vld_v[0]), 32'd1);
      chk("bp_accept_cycle_grant", 32'(rdy_v[0]), 32'd0);
      @(negedge clk);
      chk("bp_next_grant", 32'(rdy_v[0]), 32'b0010);
      next_cycle();
      req_valid = '0;
      repeat (8) @(posedge clk);

      // LAT sweep: same request on every instance, latency LAT+1 each.
      do_reset();
      set_req(2, 24'h123456, 24'h0FEDCB, 1'b1);
      @(negedge clk);
      for (int i = 0; i < 4; i++) chk("lat_grant", 32'(rdy_v[i]), 32'b0100);
      t0 = cyc;
      next_cycle();
      req_valid = '0;
      for (int i = 0; i < 4; i++) lats[i] = -1;
      for (int n = 0; n < 12; n++) begin
         @(negedge clk);
         for (int i = 0; i < 4; i++) begin
            if (vld_v[i] && lats[i] < 0) begin
               lats[i] = cyc - t0;
               chk("lat_sum", 32'(sum_v[i]), 32'h222222);
            end
         end
      end
      for (int i = 0; i < 4; i++) begin
         chk("lat_latency", 32'(lats[i]), 32'(exp_lat[i]));
         chk("lat_add_a_stable", 32'(adda_v[i]), 32'h123456);
      end

      // Reset in HOLD: outputs clear at once, no stale response, ptr back at 0.
      do_reset();
      set_req(2, 24'hABCDEF, 24'h000001, 1'b0);
      @(negedge clk);
      chk("mid_grant", 32'(rdy_v[0]), 32'b0100);
      next_cycle();
      req_valid = '0;
      @(negedge clk);
      chk("mid_busy_before", 32'(busy_v[0]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk("mid_add_a", 32'(adda_v[0]), 32'd0);
      chk("mid_rsp_id", 32'(id_v[0]), 32'd0);
      chk("mid_busy", 32'(busy_v[0]), 32'd0);
      chk("mid_rsp_valid", 32'(vld_v[0]), 32'd0);
      chk("mid_rsp_sum_cout", 32'({cout_v[0], sum_v[0]}), 32'd0);
      next_cycle();
      rst_n = 1'b1;
      set_req(1, 24'h000100, 24'h000200, 1'b0);
      set_req(3, 24'h7FFFFF, 24'h000001, 1'b1);
      @(negedge clk);
      chk("mid_ptr_restart", 32'(rdy_v[0]), 32'b0010);
      t0 = cyc;
      next_cycle();
      req_valid[1] = 1'b0;
      wait_rsp(0, t0 + 1, lat);
      chk("mid_latency", 32'(lat + 1), 32'd3);
      chk("mid_id", 32'(id_v[0]), 32'd1);
      chk("mid_sum", 32'(sum_v[0]), 32'h000300);
      @(negedge clk);
      chk("mid_grant3", 32'(rdy_v[0]), 32'b1000);
      t0 = cyc;
      next_cycle();
      req_valid = '0;
      wait_rsp(0, t0 + 1, lat);
      chk("mid_latency3", 32'(lat + 1), 32'd3);
      chk("mid_id3", 32'(id_v[0]), 32'd3);
      chk("mid_sum3", 32'({cout_v[0], sum_v[0]}), 32'h0800001);

      // Withdrawn request: requester 1 pulses during HOLD and is never granted.
      do_reset();
      set_req(0, 24'h000010, 24'h000020, 1'b0);
      req_a[1*W +: W] = 24'h000001;
      req_b[1*W +: W] = 24'h000002;
      req_cin[1]      = 1'b0;
      @(negedge clk);
      chk("wd_grant", 32'(rdy_v[0]), 32'b0001);
      next_cycle();
      req_valid = 4'b0010;
      seen1 = 0;
      @(negedge clk);
      if (rdy_v[0][1]) seen1++;
      next_cycle();
      req_valid = '0;
      for (int n = 0; n < 10; n++) begin
         @(negedge clk);
         if (rdy_v[0][1]) seen1++;
         if (vld_v[0]) chk("wd_rsp_sum", 32'(sum_v[0]), 32'h000030);
      end
      chk("wd_no_grant1", 32'(seen1), 32'd0);
      next_cycle();
      req_valid = 4'b0011;
      @(negedge clk);
      chk("wd_ptr_kept", 32'(rdy_v[0]), 32'b0010);
      next_cycle();
      req_valid = '0;
      repeat (8) @(posedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
